bin_to_bcd_display: RTL and testbench

//  Iterative double-dabble converter that turns an unsigned binary count into

---
 rtl/bin_to_bcd_display.sv | 146 ++++++++++++++
 tb/tb_bin_to_bcd_display.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_display.sv
// bin_to_bcd_display
// Iterative double-dabble converter from an unsigned binary count to packed
// BCD digits for the 8-digit LED display driver. One input bit is consumed
// per cycle, so a conversion takes IN_WIDTH cycles. Values that do not fit in
// DIGITS decimal digits are shown as all-F digits and flagged on overflow.
//
// Handshake: start is sampled only while idle (busy=0); the edge that samples
// start=1 also captures bin_in. done pulses for exactly one cycle when
// bcd_out/overflow have just been updated, and busy is already low in that
// cycle, so a new start may be presented alongside done. A start seen while
// busy is dropped, not queued.
//
// FSM state is held in state_q, visible hierarchically for checkers.
module bin_to_bcd_display #(
    parameter int IN_WIDTH = 27,
    parameter int DIGITS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_CONVERT = 1'b1;

    localparam logic [CW-1:0] LAST_COUNT = CW'(IN_WIDTH - 1);

    logic [0:0]          state_q,    state_d;
    logic [IN_WIDTH-1:0] shift_q,    shift_d;
    logic [BW-1:0]       digits_q,   digits_d;
    logic [CW-1:0]       count_q,    count_d;
    logic                ovf_acc_q,  ovf_acc_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic [BW-1:0]       bcd_q,      bcd_d;
    logic                overflow_q, overflow_d;

    logic [BW-1:0]       digits_adj;
    logic [BW-1:0]       digits_shifted;
    logic [IN_WIDTH-1:0] shift_shifted;
    logic                top_bit_out;
    logic                ovf_next;

    // Add-3 correction: each nibble >= 5 gets +3, no carry between nibbles.
    always_comb begin
        digits_adj = digits_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (digits_q[4*i +: 4] >= 4'd5) begin
                digits_adj[4*i +: 4] = digits_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // One-bit left shift of {digits, shift}; the bit leaving the top digit
    // means the value no longer fits in DIGITS decimal digits.
    always_comb begin
        digits_shifted = {digits_adj[BW-2:0], shift_q[IN_WIDTH-1]};
        shift_shifted  = {shift_q[IN_WIDTH-2:0], 1'b0};
        top_bit_out    = digits_adj[BW-1];
        ovf_next       = ovf_acc_q | top_bit_out;
    end

    // Next-state logic for the IDLE/CONVERT controller and its datapath.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        digits_d   = digits_q;
        count_d    = count_q;
        ovf_acc_d  = ovf_acc_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d   = bin_in;
                    digits_d  = '0;
                    ovf_acc_d = 1'b0;
                    count_d   = '0;
                    busy_d    = 1'b1;
                    state_d   = S_CONVERT;
                end
            end
            S_CONVERT: begin
                digits_d  = digits_shifted;
                shift_d   = shift_shifted;
                ovf_acc_d = ovf_next;
                count_d   = count_q + CW'(1);
                if (count_q == LAST_COUNT) begin
                    // Outputs only move here, so the display never sees a
                    // partially converted value.
                    bcd_d      = ovf_next ? {BW{1'b1}} : digits_shifted;
                    overflow_d = ovf_next;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    count_d    = '0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            digits_q   <= '0;
            count_q    <= '0;
            ovf_acc_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            digits_q   <= digits_d;
            count_q    <= count_d;
            ovf_acc_q  <= ovf_acc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Testbench for bin_to_bcd_display: directed vectors, held-start stream,
// mid-conversion reset and a random sweep against a divide/modulo model.
module tb_bin_to_bcd_display;

  localparam int IN_WIDTH = 27;
  localparam int DIGITS   = 8;
  localparam int LATENCY  = 27;

  logic        clk;
  logic        rst;
  logic        start;
  logic [26:0] bin_in;
  logic        busy;
  logic        done;
  logic [31:0] bcd_out;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // expected {overflow, bcd_out} and accepting-edge cycle per conversion
  logic [32:0] exp_q[$];
  int          acc_q[$];

  logic [32:0] last_out = '0;
  logic        prev_done = 1'b0;

  bin_to_bcd_display #(
    .IN_WIDTH(IN_WIDTH),
    .DIGITS  (DIGITS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .overflow(overflow)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: decimal digits by divide/modulo, all-F on overflow
  function automatic logic [32:0] bcd_model(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    if (v >= 32'd100000000) return {1'b1, 32'hFFFFFFFF};
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return {1'b0, r};
  endfunction

  // driver tasks (drive on negedge)
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      errors++;
      $display("FAIL wait_idle: busy=%0b still high after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic issue(input logic [26:0] v, input logic [32:0] exp);
    wait_idle();
    start  = 1'b1;
    bin_in = v;
    exp_q.push_back(exp);
    acc_q.push_back(cyc + 1);
    @(negedge clk);
    start  = 1'b0;
    bin_in = 27'($urandom_range(0, 134217727));
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 32'h0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy=%0b done=%0b bcd=%h ovf=%0b, required 0 0 00000000 0",
               name, busy, done, bcd_out, overflow);
    end
  endtask

  // monitor / scoreboard (sample 1 time unit after the active edge)
  always begin
    logic [32:0] e;
    int          a;
    @(posedge clk);
    #1;
    if (rst) begin
      last_out  = '0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        checks++;
        if (busy) begin
          errors++;
          $display("FAIL busy_done_overlap: busy=%0b with done=1, required 0", busy);
        end
        checks++;
        if (prev_done) begin
          errors++;
          $display("FAIL done_width: done high %0d consecutive cycles, required 1", 2);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got ovf=%0b bcd=%h, required no done", overflow, bcd_out);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          if ({overflow, bcd_out} !== e) begin
            errors++;
            $display("FAIL result: got ovf=%0b bcd=%h, required ovf=%0b bcd=%h",
                     overflow, bcd_out, e[32], e[31:0]);
          end
          checks++;
          if (cyc - a != LATENCY) begin
            errors++;
            $display("FAIL latency: got %0d cycles, required %0d", cyc - a, LATENCY);
          end
        end
        last_out = {overflow, bcd_out};
      end else begin
        checks++;
        if ({overflow, bcd_out} !== last_out) begin
          errors++;
          $display("FAIL output_hold: got ovf=%0b bcd=%h without done, required ovf=%0b bcd=%h",
                   overflow, bcd_out, last_out[32], last_out[31:0]);
        end
      end
      prev_done = done;
    end
  end

  // stimulus
  initial begin
    logic [26:0] v;
    int          n;
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset_state");

    // directed vectors with hand-computed results
    issue(27'd0,         {1'b0, 32'h00000000});
    issue(27'd12345678,  {1'b0, 32'h12345678});
    issue(27'd9,         {1'b0, 32'h00000009});
    issue(27'd10,        {1'b0, 32'h00000010});
    issue(27'd99999999,  {1'b0, 32'h99999999});
    issue(27'd100000000, {1'b1, 32'hFFFFFFFF});
    issue(27'd134217727, {1'b1, 32'hFFFFFFFF});
    issue(27'd555,       {1'b0, 32'h00000555});
    issue(27'd1000000,   {1'b0, 32'h01000000});

    // start held high with bin_in changing every cycle: accepted every 28
    wait_idle();
    for (int c = 0; c < 28 * 4; c++) begin
      v      = 27'(c * 1234567 + 89);
      start  = 1'b1;
      bin_in = v;
      if (c % 28 == 0) begin
        exp_q.push_back(bcd_model(32'(v)));
        acc_q.push_back(cyc + 1);
      end
      @(negedge clk);
    end
    start = 1'b0;

    // reset at cycle 10 of a conversion of 555: aborted, no done
    wait_idle();
    start  = 1'b1;
    bin_in = 27'd555;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("abort_reset");
    issue(27'd42, {1'b0, 32'h00000042});

    // random sweep against the model
    for (int i = 0; i < 1000; i++) begin
      v = 27'($urandom_range(0, 134217727));
      issue(v, bcd_model(32'(v)));
    end

    // drain the scoreboard
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
